// File: rtl/npc_mem_pkg.sv
// Shared types for the core memory port: arbiter FSM states, port ownership, store lengths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [3:0] WLEN_B = 4'd1;
    localparam logic [3:0] WLEN_H = 4'd2;
    localparam logic [3:0] WLEN_W = 4'd4;
    localparam logic [3:0] WLEN_D = 4'd8;

    // Streak counter width; covers MAX_LS_STREAK up to 15.
    localparam int STREAK_W = 4;

endpackage

// File: rtl/arb_streak2.sv
// Two-input priority arbiter: hi wins contention until it has won MAX_STREAK contended rounds in a row, then lo wins once.
// Latency: combinational grant in the cycle adv_i is high; streak state updates on the following edge.
// Backpressure: grants only when adv_i is high; streak is frozen otherwise.
module arb_streak2
    import npc_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_hi_i,
    input  logic req_lo_i,
    input  logic adv_i,
    output logic gnt_hi_o,
    output logic gnt_lo_o
);

    localparam logic [STREAK_W-1:0] MAX_Q = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // Grant selection and streak bookkeeping; only an arbitration cycle moves the streak.
    always_comb begin
        gnt_hi_o = 1'b0;
        gnt_lo_o = 1'b0;
        streak_d = streak_q;
        if (adv_i) begin
            if (req_hi_i && req_lo_i) begin
                if (streak_q >= MAX_Q) begin
                    gnt_lo_o = 1'b1;
                    streak_d = '0;
                end else begin
                    gnt_hi_o = 1'b1;
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else if (req_lo_i) begin
                gnt_lo_o = 1'b1;
                streak_d = '0;
            end else begin
                // No lo request this cycle: lo is not being starved, restart the count.
                gnt_hi_o = req_hi_i;
                streak_d = '0;
            end
        end
    end

    // Streak counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch (IF) and load/store (LS).
// Latency: grant @0, mem_req_valid @1, earliest mem_rsp_valid @2, *_rsp_valid @3 (new grant possible @3).
// Backpressure: request fields held in registers until mem_req_ready; requesters see ready only in the IDLE grant cycle.
module mem_port_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 64,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_wlen,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wlen,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wlen;
        logic              wen;
        logic              ren;
    } mem_req_t;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    mem_req_t          req_q, req_d;
    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]       if_rsp_data_q, if_rsp_data_d;
    logic              ls_rsp_valid_q, ls_rsp_valid_d;
    logic [DATA_W-1:0] ls_rsp_data_q, ls_rsp_data_d;

    logic if_elig;
    logic arb_adv;
    logic gnt_ls;
    logic gnt_if;

    // A fetch raised during a flush targets the old path, so it may not compete.
    assign if_elig = if_req_valid && !flush;
    // Arbitrate only when the port is free; reset forces both readies low.
    assign arb_adv = (state_q == IDLE) && !rst;

    arb_streak2 #(
        .MAX_STREAK (MAX_LS_STREAK)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_hi_i (ls_req_valid),
        .req_lo_i (if_elig),
        .adv_i    (arb_adv),
        .gnt_hi_o (gnt_ls),
        .gnt_lo_o (gnt_if)
    );

    assign ls_req_ready  = gnt_ls;
    assign if_req_ready  = gnt_if;

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = req_q.addr;
    assign mem_wdata     = req_q.wdata;
    assign mem_wlen      = req_q.wlen;
    assign mem_wen       = req_q.wen;
    assign mem_ren       = req_q.ren;

    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign ls_rsp_valid  = ls_rsp_valid_q;
    assign ls_rsp_data   = ls_rsp_data_q;

    // Next-state, request latching and response routing.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        drop_d         = drop_q;
        req_d          = req_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_data_d  = ls_rsp_data_q;

        case (state_q)
            IDLE: begin
                owner_d = OWN_NONE;
                drop_d  = 1'b0;
                if (gnt_ls) begin
                    req_d.addr  = ls_addr;
                    req_d.wdata = ls_wdata;
                    req_d.wen   = ls_wen;
                    req_d.ren   = !ls_wen;
                    req_d.wlen  = ls_wen ? ls_wlen : 4'd0;
                    owner_d     = OWN_LS;
                    state_d     = REQ;
                end else if (gnt_if) begin
                    req_d.addr  = if_addr;
                    req_d.wdata = '0;
                    req_d.wen   = 1'b0;
                    req_d.ren   = 1'b1;
                    req_d.wlen  = 4'd0;
                    owner_d     = OWN_IF;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // The memory side must still see the fetch through; only its response is dropped.
                if (flush && owner_q == OWN_IF) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    drop_d  = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_rsp_valid_d = !(drop_q || flush);
                        if_rsp_data_d  = req_q.addr[2] ? mem_rsp_data[32 +: 32]
                                                       : mem_rsp_data[0 +: 32];
                    end else if (owner_q == OWN_LS) begin
                        ls_rsp_valid_d = 1'b1;
                        ls_rsp_data_d  = req_q.wen ? '0 : mem_rsp_data;
                    end
                end else if (flush && owner_q == OWN_IF) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State, latched request and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_NONE;
            drop_q         <= 1'b0;
            req_q          <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            drop_q         <= drop_d;
            req_q          <= req_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_data_q  <= ls_rsp_data_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, stalled store, streak fairness, flush, mid-transaction reset, load under flush.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 time unit later.
// Backpressure: the bench plays the memory, stalling mem_req_ready where a scenario needs it.
module tb_mem_port_arbiter;
    import npc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [3:0]  ls_wlen;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic        mem_ren;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_wlen;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W        (64),
        .DATA_W        (64),
        .MAX_LS_STREAK (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_wen        (ls_wen),
        .ls_wdata      (ls_wdata),
        .ls_wlen       (ls_wlen),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_ren       (mem_ren),
        .mem_wdata     (mem_wdata),
        .mem_wlen      (mem_wlen),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush         = 1'b0;
        if_req_valid  = 1'b0;
        if_addr       = '0;
        ls_req_valid  = 1'b0;
        ls_addr       = '0;
        ls_wen        = 1'b0;
        ls_wdata      = '0;
        ls_wlen       = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        step();
        step();
        #1;
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", {if_req_ready, ls_req_ready});
        end
        checks++;
        if ({mem_req_valid, mem_ren, mem_wen, if_rsp_valid, ls_rsp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_req_valid, mem_ren, mem_wen, if_rsp_valid, ls_rsp_valid});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wlen, if_rsp_data, ls_rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        if_req_valid = 1'b1;
        if_addr      = 64'h8000_0004;
        #1;
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_grant: got %b want 10", {if_req_ready, ls_req_ready});
        end
        step();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_ren, mem_wen, mem_wlen, mem_addr} !== {3'b110, 4'd0, 64'h8000_0004}) begin
            errors++;
            $display("FAIL fetch_req: v%b r%b w%b len %h addr %h want v1 r1 w0 len 0 addr 80000004",
                     mem_req_valid, mem_ren, mem_wen, mem_wlen, mem_addr);
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        checks++;
        if (if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_rsp: got %b want 0", if_rsp_valid);
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'hAAAA_BBBB}) begin
            errors++;
            $display("FAIL fetch_rsp: valid %b data %h want 1 aaaabbbb", if_rsp_valid, if_rsp_data);
        end
        step();
        checks++;
        if (if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp_pulse: got %b want 0", if_rsp_valid);
        end
    endtask

    task automatic test_store_stall();
        ls_req_valid = 1'b1;
        ls_wen       = 1'b1;
        ls_addr      = 64'h8000_1000;
        ls_wdata     = 64'h11;
        ls_wlen      = WLEN_B;
        #1;
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL store_grant: got %b want 01", {if_req_ready, ls_req_ready});
        end
        step();
        ls_req_valid = 1'b0;
        ls_wdata     = 64'hFFFF;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready = (c == 3);
            // Stray response while the request is still pending must be ignored.
            mem_rsp_valid = (c == 1);
            #1;
            checks++;
            if ({mem_req_valid, mem_wen, mem_ren, mem_addr, mem_wdata, mem_wlen, ls_rsp_valid} !==
                {3'b110, 64'h8000_1000, 64'h11, WLEN_B, 1'b0}) begin
                errors++;
                $display("FAIL store_hold_%0d: v%b w%b r%b addr %h wdata %h len %h rsp %b want v1 w1 r0 80001000 11 1 0",
                         c, mem_req_valid, mem_wen, mem_ren, mem_addr, mem_wdata, mem_wlen, ls_rsp_valid);
            end
            step();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h5555_5555_5555_5555;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_wait_valid: got %b want 0", mem_req_valid);
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ls_rsp_valid, ls_rsp_data} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL store_ack: valid %b data %h want 1 0", ls_rsp_valid, ls_rsp_data);
        end
        step();
        checks++;
        if (ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_ack_pulse: got %b want 0", ls_rsp_valid);
        end
        ls_wen = 1'b0;
    endtask

    task automatic test_streak();
        // Bit k set means grant k must go to IF.
        logic [9:0] exp_if;
        int n;
        int cyc;
        exp_if = 10'b10_0001_0000;
        n = 0;
        cyc = 0;
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0200;
        ls_req_valid  = 1'b1;
        ls_wen        = 1'b0;
        ls_addr       = 64'h8000_3000;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0;
        while (n < 10 && cyc < 60) begin
            #1;
            if (if_req_ready && ls_req_ready) begin
                checks++;
                errors++;
                $display("FAIL streak_onehot: both readies high at grant %0d", n);
            end else if (if_req_ready || ls_req_ready) begin
                checks++;
                if (if_req_ready !== exp_if[n]) begin
                    errors++;
                    $display("FAIL streak_grant_%0d: if_ready %b want %b", n, if_req_ready, exp_if[n]);
                end
                n++;
            end
            step();
            cyc++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL streak_timeout: saw %0d grants want 10", n);
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        step();
        step();
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        step();
    endtask

    task automatic test_flush_fetch();
        if_req_valid = 1'b1;
        if_addr      = 64'h8000_0040;
        flush        = 1'b1;
        #1;
        checks++;
        if (if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_grant: got %b want 0", if_req_ready);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_fetch_grant: got %b want 1", if_req_ready);
        end
        step();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0100;
        #1;
        checks++;
        if (if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_ready: got %b want 0", if_req_ready);
        end
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({if_rsp_valid, if_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_drop: rsp %b ready %b want rsp 0 ready 1", if_rsp_valid, if_req_ready);
        end
        step();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 64'h8000_0100}) begin
            errors++;
            $display("FAIL refetch_req: v%b addr %h want 1 80000100", mem_req_valid, mem_addr);
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h1234_5678_9ABC_DEF0;
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h9ABC_DEF0}) begin
            errors++;
            $display("FAIL refetch_rsp: valid %b data %h want 1 9abcdef0", if_rsp_valid, if_rsp_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ls_req_valid = 1'b1;
        ls_wen       = 1'b0;
        ls_addr      = 64'h8000_3008;
        #1;
        checks++;
        if (ls_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: got %b want 1", ls_req_ready);
        end
        step();
        ls_req_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: got %b want 1", mem_req_valid);
        end
        rst = 1'b1;
        step();
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, if_req_ready, ls_req_ready, mem_addr} !== {3'b000, 64'h0}) begin
            errors++;
            $display("FAIL rstmid_state: v%b ifr%b lsr%b addr %h want 0 0 0 0",
                     mem_req_valid, if_req_ready, ls_req_ready, mem_addr);
        end
        rst          = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h7777_7777_7777_7777;
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ls_rsp_valid, if_rsp_valid, mem_req_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_late_rsp: ls %b if %b req %b want 000", ls_rsp_valid, if_rsp_valid, mem_req_valid);
        end
        step();
    endtask

    task automatic test_load_flush();
        ls_req_valid = 1'b1;
        ls_wen       = 1'b0;
        ls_addr      = 64'h8000_2008;
        flush        = 1'b1;
        #1;
        checks++;
        if (ls_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_grant: got %b want 1", ls_req_ready);
        end
        step();
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_ren, mem_wen, mem_addr} !== {3'b110, 64'h8000_2008}) begin
            errors++;
            $display("FAIL load_req: v%b r%b w%b addr %h want 1 1 0 80002008",
                     mem_req_valid, mem_ren, mem_wen, mem_addr);
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        flush         = 1'b0;
        #1;
        checks++;
        if ({ls_rsp_valid, ls_rsp_data} !== {1'b1, 64'hDEAD_BEEF_CAFE_F00D}) begin
            errors++;
            $display("FAIL load_rsp: valid %b data %h want 1 deadbeefcafef00d", ls_rsp_valid, ls_rsp_data);
        end
        step();
        checks++;
        if (ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_rsp_pulse: got %b want 0", ls_rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_stall();
        test_streak();
        test_flush_fetch();
        test_reset_mid();
        test_load_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between two requesters: instruction fetch (IF) and load/store (LS).
- The memory port carries address, wdata, wlen, wen and ren, with one transaction outstanding at a time.
- Sits between ifu/mmu and the memory model, replacing their direct port use. This allows a single-ported, multi-cycle memory.
- LS normally wins contention. A streak counter guarantees IF forward progress; the flush input discards stale fetch responses.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width.
- MAX_LS_STREAK, 4, consecutive contended LS grants before IF is forced to win (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush (jump/branch taken); invalidates the in-flight fetch
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address, 4-byte aligned
- if_rsp_valid  out  1  fetch data valid, 1-cycle pulse
- if_rsp_data  out  32  instruction word
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  ADDR_W  LS address
- ls_wen  in  1  1 = store, 0 = load
- ls_wdata  in  DATA_W  store data
- ls_wlen  in  4  store byte length (1/2/4/8)
- ls_rsp_valid  out  1  load data or store ack, 1-cycle pulse
- ls_rsp_data  out  DATA_W  load data (0 for stores)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  memory address
- mem_wen  out  1  write enable
- mem_ren  out  1  read enable
- mem_wdata  out  DATA_W  write data
- mem_wlen  out  4  write length
- mem_rsp_valid  in  1  memory response (read data or write ack)
- mem_rsp_data  in  DATA_W  read data

Behaviour:
- Reset: all outputs 0. State IDLE, streak counter 0, drop flag 0, owner NONE.
- States:
  - IDLE: arbitrate.
  - REQ: mem_req_valid=1 and request fields driven from registers, held stable until mem_req_ready.
  - WAIT: awaiting mem_rsp_valid.
- Arbitration happens only in IDLE, combinationally in the same cycle:
  - IF is eligible when if_req_valid && !flush.
  - LS only: grant LS.
  - IF only: grant IF.
  - Both requesting, streak < MAX_LS_STREAK: grant LS and increment streak.
  - Both requesting, streak == MAX_LS_STREAK: grant IF.
  - Any IF grant, or a cycle with no IF request, clears streak.
- Grant: the winner's *_req_ready is 1 in that IDLE cycle only. Fields are latched, owner is recorded, next state is REQ. The ready outputs are 0 in all other states.
- Request fields:
  - IF: mem_ren=1, mem_wen=0, mem_wlen=0.
  - LS load: mem_ren=1, mem_wen=0.
  - LS store: mem_wen=1, mem_ren=0, mem_wlen=ls_wlen.
- REQ→WAIT when mem_req_ready. mem_req_valid never drops before acceptance.
- WAIT→IDLE when mem_rsp_valid. The response is registered: *_rsp_valid pulses the cycle after mem_rsp_valid.
- Instruction data: if_rsp_data = addr[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0], with addr[2] taken from the latched address.
- Minimum request→response latency is 3 cycles: grant @0, mem_req_valid @1 (ready @1), mem_rsp_valid @2, *_rsp_valid @3. A new grant is possible @3.
- Flush while owner==IF in REQ or WAIT:
  - Set the drop flag.
  - The transaction still completes on the memory side, but if_rsp_valid is suppressed.
  - The drop flag clears on return to IDLE.
- Flush in the same cycle as mem_rsp_valid for an IF owner also drops the response.
- Flush never affects LS transactions.
- mem_rsp_valid in IDLE or REQ is a protocol error: ignored, no response pulse.
- Reset mid-transaction:
  - Next edge returns to IDLE with mem_req_valid=0.
  - A pending memory response after reset is ignored (IDLE rule).
- Requesters must hold valid and fields stable until ready. The block does not buffer unaccepted requests.

Decomposition:
- Shared package npc_mem_pkg:
  - state enum {IDLE, REQ, WAIT}
  - owner enum {NONE, IF, LS}
  - wlen constants WLEN_B=1, WLEN_H=2, WLEN_W=4, WLEN_D=8
- Sub-module arb_streak2: 2-input priority arbiter with starvation counter. Inputs are the two request lines and an advance enable; outputs are one-hot grants. Instantiated once.

Test Plan:
- Single fetch, addr 0x80000004; memory ready immediately, rsp 0xAAAABBBB_CCCCDDDD one cycle later → if_rsp_valid @3, if_rsp_data=0xAAAABBBB; mem_ren=1, mem_wen=0.
- Store, addr 0x80001000, wdata 0x11, wlen 1; memory stalls mem_req_ready for 3 cycles → mem_req_valid and fields held stable for 4 cycles; ls_rsp_valid once, ls_rsp_data=0.
- Both requesting continuously, MAX_LS_STREAK=4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF…; no IF starvation.
- Fetch in WAIT, flush pulsed → no if_rsp_valid. A subsequent IF request (addr 0x80000100) is granted in the IDLE cycle after the response and returns correct data.
- rst asserted while in REQ → next cycle mem_req_valid=0, both readies 0; a late mem_rsp_valid produces no rsp pulse.
- Load from 0x80002008 returning 0xDEADBEEF_CAFEF00D while flush pulses → ls_rsp_valid with full 64-bit data; flush has no effect.
